jtpang_gfx_romslot: RTL

Graphics ROM responder for the Pang video layers. It serves the 32-bit `rom_addr`/`rom_cs`/`rom_data` fetch interface that the character tile layer drives, turning each request into two sequential 16-bit reads on a downstream memory port (SDRAM bank arbiter side). It reassembles the two halves and flags completion with `rom_ok`. It sits between the tile layer and the SDRAM controller, in the same `clk` domain as the layer's scan side.

---
 rtl/jtpang_gfx_romslot.sv | 133 +++++++++++++
 1 files changed

// File: rtl/jtpang_gfx_romslot.sv
// Pang graphics ROM slot: each 32-bit tile fetch becomes two 16-bit downstream reads.
// Define JTPANG_ROMCACHE_EN to keep the last completed fetch in a one-entry cache.
module jtpang_gfx_romslot #(
  parameter int AW = 18,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rom_cs,
  input  logic [AW-1:0] rom_addr,
  output logic [31:0]   rom_data,
  output logic          rom_ok,
  output logic [AW-1:0] mem_addr,
  output logic          mem_req,
  input  logic          mem_ack,
  input  logic          mem_rdy,
  input  logic [DW-1:0] mem_din
);

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE} state_t;

  state_t        state;
  logic [AW-2:0] cur_addr;
  logic [AW-2:0] req_addr;
  logic          addr_same;
  logic          launch;
  logic          cache_hit;
  logic [31:0]   hit_data;
  logic          unused_bit;

  assign req_addr   = rom_addr[AW-1:1];
  assign addr_same  = req_addr == cur_addr;
  assign unused_bit = rom_addr[0];

  // A new request is evaluated from IDLE, or straight out of DONE when the
  // layer has already moved on to a different address.
  assign launch = rom_cs && ((state == IDLE) || ((state == DONE) && !addr_same));

`ifdef JTPANG_ROMCACHE_EN
  logic          cache_valid;
  logic [AW-2:0] cache_addr;
  logic [31:0]   cache_data;

  assign cache_hit = cache_valid && (cache_addr == req_addr);
  assign hit_data  = cache_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_valid <= 1'b0;
      cache_addr  <= '0;
      cache_data  <= '0;
    end else if (state == WAIT1 && mem_rdy && rom_cs && addr_same) begin
      cache_valid <= 1'b1;
      cache_addr  <= cur_addr;
      cache_data  <= {mem_din, rom_data[15:0]};
    end
  end
`else
  assign cache_hit = 1'b0;
  assign hit_data  = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cur_addr <= '0;
      rom_data <= '0;
      rom_ok   <= 1'b0;
      mem_addr <= '0;
      mem_req  <= 1'b0;
    end else begin
      case (state)
        IDLE: ;
        REQ0, REQ1: begin
          // An acknowledged word always completes, even if the layer moved on.
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= (state == REQ0) ? WAIT0 : WAIT1;
          end else if (!rom_cs) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end else if (!addr_same) begin
            cur_addr <= req_addr;
            mem_addr <= {req_addr, 1'b0};
            state    <= REQ0;
          end
        end
        WAIT0, WAIT1: begin
          if (mem_rdy) begin
            if (!rom_cs) begin
              state <= IDLE;
            end else if (!addr_same) begin
              cur_addr <= req_addr;
              mem_addr <= {req_addr, 1'b0};
              mem_req  <= 1'b1;
              state    <= REQ0;
            end else if (state == WAIT0) begin
              rom_data[15:0] <= mem_din;
              mem_addr       <= {cur_addr, 1'b1};
              mem_req        <= 1'b1;
              state          <= REQ1;
            end else begin
              rom_data[31:16] <= mem_din;
              rom_ok          <= 1'b1;
              state           <= DONE;
            end
          end
        end
        DONE: begin
          if (!(rom_cs && addr_same)) begin
            rom_ok <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (launch) begin
        cur_addr <= req_addr;
        if (cache_hit) begin
          rom_data <= hit_data;
          rom_ok   <= 1'b1;
          state    <= DONE;
        end else begin
          mem_addr <= {req_addr, 1'b0};
          mem_req  <= 1'b1;
          state    <= REQ0;
        end
      end
    end
  end

endmodule
